// File: rtl/uart_packet_tx.sv
// uart_packet_tx: serialises a framed packet (header, NBYTES payload bytes,
// 8-bit additive checksum) on a UART line with configurable parity/stop bits.
module uart_packet_tx #(
    parameter int          CLK_HZ    = 27_000_000,
    parameter int          BAUD      = 115_200,
    parameter int          NBYTES    = 4,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [8*NBYTES-1:0]   payload,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NBYTES + 2);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES + 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [8*NBYTES-1:0]    payload_q;
    logic [7:0]             csum_q;
    logic [7:0]             cur_byte;
    logic                   par_bit;
    logic                   accept;
    logic                   baud_last;

    // Modulo-256 sum of all payload bytes; header excluded.
    function automatic logic [7:0] sum_bytes(input logic [8*NBYTES-1:0] p);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < NBYTES; k++) s = s + p[8*k +: 8];
        return s;
    endfunction

    assign busy = busy_q;
    assign done = done_q;
    assign tx   = tx_q;

    assign accept    = (state_q == S_IDLE) && start;
    assign baud_last = (baud_q == BAUD_LAST);
    assign par_bit   = (PARITY == 2) ? ~(^cur_byte) : (^cur_byte);

    // Byte currently on the wire, selected by the packet byte index.
    always_comb begin
        cur_byte = HEADER;
        if (idx_q == LAST_IDX)
            cur_byte = csum_q;
        else if (idx_q != '0)
            cur_byte = payload_q[8*(int'(idx_q) - 1) +: 8];
    end

    // Next-state and next-output logic; tx is computed one cycle ahead so the
    // line itself comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                            tx_d    = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_START;
                            idx_d   = idx_q + 1'b1;
                            tx_d    = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Payload and checksum are captured only when a request is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload_q <= '0;
            csum_q    <= '0;
        end else if (accept) begin
            payload_q <= payload;
            csum_q    <= sum_bytes(payload);
        end
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: three transmitter configurations (no parity/1 stop,
// even/2 stop, odd/1 stop) checked cycle by cycle against a bit-list model.
module tb_uart_packet_tx;

    localparam int DIV = 10;
    localparam int NB  = 2;
    localparam int ND  = 3;
    localparam int PAR [ND] = '{0, 1, 2};
    localparam int STP [ND] = '{1, 2, 1};

    logic            clk = 1'b0;
    logic            resetn;
    logic [15:0]     payload;
    logic [ND-1:0]   start_v;
    logic [ND-1:0]   busy_v;
    logic [ND-1:0]   done_v;
    logic [ND-1:0]   tx_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_packet_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .NBYTES(NB), .HEADER(8'hA5),
                     .PARITY(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .resetn(resetn), .payload(payload), .start(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));

    uart_packet_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .NBYTES(NB), .HEADER(8'hA5),
                     .PARITY(1), .STOP_BITS(2)) u_d1 (
        .clk(clk), .resetn(resetn), .payload(payload), .start(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));

    uart_packet_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .NBYTES(NB), .HEADER(8'hA5),
                     .PARITY(2), .STOP_BITS(1)) u_d2 (
        .clk(clk), .resetn(resetn), .payload(payload), .start(start_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every configuration idle: line high, not busy, no done.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                check($sformatf("idle_tx d%0d", d), tx_v[d], 1);
                check($sformatf("idle_busy d%0d", d), busy_v[d], 0);
                check($sformatf("idle_done d%0d", d), done_v[d], 0);
            end
        end
    endtask

    // Expected line bits for one packet, built from the framing rules.
    task automatic build_bits(input int d, input logic [15:0] pl, output bit q[$]);
        int bytes [4];
        q = {};
        bytes[0] = 'hA5;
        bytes[1] = pl[7:0];
        bytes[2] = pl[15:8];
        bytes[3] = (bytes[1] + bytes[2]) % 256;
        for (int b = 0; b < 4; b++) begin
            q.push_back(1'b0);
            for (int k = 0; k < 8; k++) q.push_back(bit'((bytes[b] >> k) & 1));
            if (PAR[d] != 0) q.push_back(bit'(($countones(bytes[b][7:0]) % 2) ^ (PAR[d] == 2 ? 1 : 0)));
            for (int s = 0; s < STP[d]; s++) q.push_back(1'b1);
        end
    endtask

    // Request a packet at the current negedge and follow it to its done cycle.
    // mid_at > 0 pulses a stray start (with zero payload) at that busy cycle.
    task automatic run_pkt(input int d, input logic [15:0] pl, input int mid_at);
        bit q[$];
        int n;
        build_bits(d, pl, q);
        n = q.size() * DIV;
        payload    = pl;
        start_v[d] = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start_v[d] = (c == mid_at);
            if (c == mid_at) payload = 16'h0000;
            check($sformatf("tx d%0d c%0d", d, c), tx_v[d], q[(c-1)/DIV]);
            check($sformatf("busy d%0d c%0d", d, c), busy_v[d], 1);
            check($sformatf("done_early d%0d c%0d", d, c), done_v[d], 0);
        end
        @(negedge clk);
        start_v[d] = 1'b0;
        check($sformatf("done d%0d", d), done_v[d], 1);
        check($sformatf("busy_end d%0d", d), busy_v[d], 0);
        check($sformatf("tx_end d%0d", d), tx_v[d], 1);
    endtask

    initial begin
        resetn  = 1'b0;
        start_v = '0;
        payload = '0;

        // Reset held for 5 cycles, then quiet without start.
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                check($sformatf("rst_tx d%0d", d), tx_v[d], 1);
                check($sformatf("rst_busy d%0d", d), busy_v[d], 0);
                check($sformatf("rst_done d%0d", d), done_v[d], 0);
            end
        end
        resetn = 1'b1;
        idle(5);

        // Basic, even parity / two stop, odd parity, checksum wrap.
        run_pkt(0, 16'h1234, 0);
        idle(3);
        run_pkt(1, 16'h1234, 0);
        idle(3);
        run_pkt(2, 16'h1234, 0);
        idle(3);
        run_pkt(0, 16'hFFFF, 0);
        idle(2);
        run_pkt(1, 16'hFFFF, 0);
        idle(2);

        // Ignored start mid-packet, then back-to-back start in the done cycle.
        run_pkt(0, 16'h1234, 50);
        run_pkt(0, 16'h0102, 0);
        idle(2);
        run_pkt(1, 16'h1234, 77);
        run_pkt(1, 16'h0102, 0);
        idle(2);

        // Random payloads across all configurations.
        for (int i = 0; i < 6; i++) begin
            run_pkt(i % ND, 16'($urandom), 0);
            idle(2);
        end

        // Reset during the data bits of payload byte 1 (second byte on the wire).
        payload    = 16'h5A3C;
        start_v[0] = 1'b1;
        for (int c = 1; c <= 125; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        check("pre_rst_busy", busy_v[0], 1);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_tx", tx_v[0], 1);
        check("rst_async_busy", busy_v[0], 0);
        repeat (4) begin
            @(negedge clk);
            check("rst_hold_done", done_v[0], 0);
            check("rst_hold_tx", tx_v[0], 1);
        end
        resetn = 1'b1;
        idle(4);
        run_pkt(0, 16'($urandom), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
